// File: rtl/memory_port_arbiter.sv
`timescale 1ns/1ps
// Purpose: round-robin arbiter merging N_PORTS requesters onto one in-order memory port.
// Latency: mem_valid 1 cycle after req_ready; responses forwarded in the same cycle (0 cycles).
// Backpressure: one-entry output stage holds while mem_ready=0; grants stop at MAX_OUTST in flight.
// Option: define MEM_ARB_ALIGN_CHECK_EN to answer misaligned accesses locally with rsp_err.
module memory_port_arbiter #(
    parameter int N_PORTS   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PORTS-1:0]         req_valid,
    output logic [N_PORTS-1:0]         req_ready,
    input  logic [N_PORTS-1:0]         req_we,
    input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
    input  logic [N_PORTS*2-1:0]       req_width,
    input  logic [N_PORTS*DATA_W-1:0]  req_wdata,
    output logic [N_PORTS-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [N_PORTS-1:0]         rsp_err,
    output logic                       mem_valid,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [1:0]                 mem_width,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ready,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_W-1:0]          mem_rdata
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [IDX_W-1:0]  last_q, last_d;
    logic              stg_vld_q, stg_vld_d;
    logic              stg_we_q, stg_we_d;
    logic [ADDR_W-1:0] stg_addr_q, stg_addr_d;
    logic [1:0]        stg_width_q, stg_width_d;
    logic [DATA_W-1:0] stg_wdata_q, stg_wdata_d;
    logic [IDX_W-1:0]  stg_id_q, stg_id_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  id_mem_q [MAX_OUTST];

    logic              found;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_width;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_misal;
    logic              gnt;
    logic              fwd;
    logic              hs;
    logic              pop;
    logic [IDX_W-1:0]  head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Round-robin pick: first valid port searching upward from last granted + 1
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        sel_idx = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = IDX_W'((int'(last_q) + 1 + k) % N_PORTS);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign sel_we    = req_we[sel_idx];
    assign sel_addr  = req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
    assign sel_width = req_width[int'(sel_idx)*2 +: 2];
    assign sel_wdata = req_wdata[int'(sel_idx)*DATA_W +: DATA_W];

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // Alignment rule for the selected request; width code 3 is reserved and always rejected
    always_comb begin
        case (sel_width)
            2'd1:    sel_misal = sel_addr[0];
            2'd2:    sel_misal = (sel_addr[1:0] != 2'b00);
            2'd3:    sel_misal = 1'b1;
            default: sel_misal = 1'b0;
        endcase
    end
`else
    assign sel_misal = 1'b0;
`endif

    assign hs      = stg_vld_q & mem_ready;
    assign pop     = mem_rsp_valid & (outst_q != '0);
    assign head_id = id_mem_q[rd_ptr_q];

    // Grant needs a free (or draining) stage and room for one more in flight. A misaligned
    // winner waits for a fully idle port rather than being skipped, so its error response
    // cannot collide with a forwarded one.
    always_comb begin
        gnt = found && (!stg_vld_q || mem_ready)
              && ((int'(outst_q) + int'(stg_vld_q)) < MAX_OUTST);
        if (sel_misal && ((outst_q != '0) || stg_vld_q)) begin
            gnt = 1'b0;
        end
        fwd = gnt && !sel_misal;
    end

    // One-hot ready to the winner, forced low while reset is asserted
    always_comb begin
        req_ready = '0;
        if (gnt && rst_n) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    // Next state for arbitration pointer, output stage, in-flight count and ID FIFO pointers
    always_comb begin
        last_d      = last_q;
        stg_vld_d   = stg_vld_q;
        stg_we_d    = stg_we_q;
        stg_addr_d  = stg_addr_q;
        stg_width_d = stg_width_q;
        stg_wdata_d = stg_wdata_q;
        stg_id_d    = stg_id_q;
        outst_d     = outst_q;
        wr_ptr_d    = hs  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        if (gnt) begin
            last_d = sel_idx;
        end
        if (hs) begin
            stg_vld_d = 1'b0;
        end
        if (fwd) begin
            stg_vld_d   = 1'b1;
            stg_we_d    = sel_we;
            stg_addr_d  = sel_addr;
            stg_width_d = sel_width;
            stg_wdata_d = sel_wdata;
            stg_id_d    = sel_idx;
        end
        if (hs && !pop) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (pop && !hs) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    // Control and stage registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= IDX_W'(N_PORTS - 1);
            stg_vld_q   <= 1'b0;
            stg_we_q    <= 1'b0;
            stg_addr_q  <= '0;
            stg_width_q <= '0;
            stg_wdata_q <= '0;
            stg_id_q    <= '0;
            outst_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            last_q      <= last_d;
            stg_vld_q   <= stg_vld_d;
            stg_we_q    <= stg_we_d;
            stg_addr_q  <= stg_addr_d;
            stg_width_q <= stg_width_d;
            stg_wdata_q <= stg_wdata_d;
            stg_id_q    <= stg_id_d;
            outst_q     <= outst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // ID FIFO storage; occupancy lives in the pointers and count, so no reset needed
    always_ff @(posedge clk) begin
        if (hs) begin
            id_mem_q[wr_ptr_q] <= stg_id_q;
        end
    end

    assign mem_valid = stg_vld_q;
    assign mem_we    = stg_we_q;
    assign mem_addr  = stg_addr_q;
    assign mem_width = stg_width_q;
    assign mem_wdata = stg_wdata_q;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic             err_vld_q;
    logic [IDX_W-1:0] err_id_q;

    // Local error response one cycle after a misaligned grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vld_q <= 1'b0;
            err_id_q  <= '0;
        end else begin
            err_vld_q <= gnt && sel_misal;
            err_id_q  <= sel_idx;
        end
    end
`endif

    // Response routing: memory responses go to the FIFO head's port; local errors override
    always_comb begin
        rsp_valid = '0;
        rsp_err   = '0;
        rsp_rdata = mem_rdata;
        if (pop) begin
            rsp_valid[head_id] = 1'b1;
        end
`ifdef MEM_ARB_ALIGN_CHECK_EN
        if (err_vld_q) begin
            rsp_valid[err_id_q] = 1'b1;
            rsp_err[err_id_q]   = 1'b1;
            rsp_rdata           = '0;
        end
`endif
    end

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter MAX_OUTST, default 4, maximum outstanding downstream requests (1..16).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, N_PORTS, per-port request valid.
REQ-008 SHALL have port req_ready, output, N_PORTS, per-port request accepted this cycle.
REQ-009 SHALL have port req_we, input, N_PORTS, per-port write enable.
REQ-010 SHALL have port req_addr, input, N_PORTS*ADDR_W, packed per-port address (port i at [i*ADDR_W +: ADDR_W]).
REQ-011 SHALL have port req_width, input, N_PORTS*2, packed access width (0=BYTE, 1=HALF, 2=WORD, 3=reserved).
REQ-012 SHALL have port req_wdata, input, N_PORTS*DATA_W, packed write data.
REQ-013 SHALL have port rsp_valid, output, N_PORTS, one-hot response strobe to the originating port.
REQ-014 SHALL have port rsp_rdata, output, DATA_W, response data, broadcast to all ports.
REQ-015 SHALL have port rsp_err, output, N_PORTS, misalignment error flag, qualified by rsp_valid.
REQ-016 SHALL have ports mem_valid/mem_we (output, 1), mem_addr (output, ADDR_W), mem_width (output, 2), mem_wdata (output, DATA_W): downstream request.
REQ-017 SHALL have port mem_ready, input, 1, downstream accepts the request when mem_valid & mem_ready.
REQ-018 SHALL have ports mem_rsp_valid (input, 1) and mem_rdata (input, DATA_W): one in-order response per accepted request, reads and writes alike.

Function
REQ-019 SHALL arbitrate round-robin: priority begins at (last granted port + 1) mod N_PORTS.
REQ-020 SHALL assert at most one req_ready bit per cycle, and only for a port with req_valid=1.
REQ-021 SHALL register the granted request into a one-entry output stage, so mem_valid rises 1 cycle after req_ready.
REQ-022 SHALL hold the mem_* outputs stable while mem_valid=1 and mem_ready=0.
REQ-023 SHALL grant only when the output stage is empty or draining this cycle, and (outstanding + stage occupancy) < MAX_OUTST.
REQ-024 SHALL push the granted port index into an ID FIFO of depth MAX_OUTST on every downstream handshake.
REQ-025 SHALL drive rsp_valid[head ID]=mem_rsp_valid combinationally, pass mem_rdata to rsp_rdata, and pop the FIFO (0-cycle response latency).
REQ-026 SHALL keep the outstanding count unchanged when a handshake and a mem_rsp_valid occur in the same cycle.
REQ-027 SHALL ignore mem_rsp_valid when the outstanding count is 0: no rsp_valid, no pointer change.
REQ-028 SHALL wrap FIFO pointers modulo MAX_OUTST, including at non-power-of-two depths.
REQ-029 SHALL drive rsp_err=0 and rsp_rdata=mem_rdata on every forwarded response.

Reset
REQ-030 SHALL, on rst_n=0, immediately clear req_ready, rsp_valid, rsp_err, mem_valid, the outstanding count and the FIFO, and set last-granted to N_PORTS-1.
REQ-031 SHALL discard all in-flight requests on reset mid-operation; responses arriving after reset fall under REQ-027.

Configuration
REQ-032 SHALL, with MEM_ARB_ALIGN_CHECK_EN defined, treat HALF with addr[0]=1, WORD with addr[1:0]!=0, or width=3 as misaligned.
REQ-033 SHALL grant a misaligned request only when outstanding=0 and the stage is empty, never forward it, and assert rsp_valid and rsp_err for that port 1 cycle after req_ready, with rsp_rdata=0.
REQ-034 SHALL, without MEM_ARB_ALIGN_CHECK_EN, forward all requests unchecked and tie rsp_err to 0.

Verification
REQ-035 SHALL cover: ports 0 and 1 both valid continuously, mem_ready=1 -> grants alternate 0,1,0,1; first grant goes to port 0.
REQ-036 SHALL cover: MAX_OUTST=4, mem_ready=1, no responses -> exactly 4 handshakes, then req_ready=0 until a mem_rsp_valid arrives.
REQ-037 SHALL cover: port1 read addr 0x10, then port0 read addr 0x20; responses 0xAAAA, 0xBBBB -> rsp_valid[1] with 0xAAAA, then rsp_valid[0] with 0xBBBB.
REQ-038 SHALL cover: mem_ready=0 for 3 cycles with a write 0x40/0xDEADBEEF pending -> mem_* stable for all 3 cycles.
REQ-039 SHALL cover, with MEM_ARB_ALIGN_CHECK_EN: port0 WORD read at 0x102 -> mem_valid stays 0, and rsp_valid[0]=rsp_err[0]=1 one cycle after grant.
REQ-040 SHALL cover: rst_n low with 2 requests outstanding -> all outputs 0 asynchronously; a late mem_rsp_valid produces no rsp_valid.
